antilog_expander32: RTL

- Inverse of the leading-one/mantissa encoder used in the log-domain datapath.
- Takes a characteristic k and mantissa m1, and rebuilds the 32-bit integer num ≈ (1.m1) × 2^k.
- Serial barrel right-shifter: one stage per cycle (16/8/4/2/1), with valid/ready handshakes on input and output.
- Sits on the result side of the log-domain multiplier/divider, converting log-domain sums back to linear integers.

---
 rtl/antilog_expander32_pkg.sv | 8 +
 rtl/antilog_expander32.sv | 68 ++++++
 2 files changed

// File: rtl/antilog_expander32_pkg.sv
// antilog_expander32_pkg: widths, state encoding and stage count shared by the antilog expander.
package antilog_expander32_pkg;
    localparam int NUM_LENGTH = 32;
    localparam int K_LENGTH = 5;
    localparam int M1_LENGTH = 8;
    localparam logic [2:0] NUM_STAGES = 3'd5;
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
endpackage

// File: rtl/antilog_expander32.sv
// antilog_expander32: rebuilds (1.m1) * 2^k as a 32-bit integer with a serial 16/8/4/2/1 right shifter.
module antilog_expander32
    import antilog_expander32_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [K_LENGTH-1:0]   in_k,
    input  logic [M1_LENGTH-1:0]  in_m1,
    input  logic                  in_zero,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [NUM_LENGTH-1:0] out_num,
    output logic                  out_exact
);
    state_t                r_state;
    logic [2:0]            r_stage;
    logic [NUM_LENGTH-1:0] r_acc;
    logic [K_LENGTH-1:0]   r_kinv;
    logic                  r_sticky;
    logic                  r_zero_q;
    logic [4:0]            w_amt;
    logic [NUM_LENGTH-1:0] w_mask;
    logic                  w_do;

    assign w_amt  = 5'd16 >> r_stage;
    assign w_do   = |(r_kinv & (5'b10000 >> r_stage));
    assign w_mask = (32'd1 << w_amt) - 32'd1;

    assign in_ready  = (r_state == IDLE) && !rst;
    assign out_valid = (r_state == DONE);
    // Outputs are gated to zero outside DONE so reset and aborted requests never show stale data.
    assign out_num   = (out_valid && !r_zero_q) ? r_acc : '0;
    assign out_exact = out_valid && (r_zero_q || !r_sticky);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_stage  <= '0;
            r_acc    <= '0;
            r_kinv   <= '0;
            r_sticky <= 1'b0;
            r_zero_q <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (in_valid) begin
                    r_acc    <= {1'b1, in_m1, {(NUM_LENGTH-M1_LENGTH-1){1'b0}}};
                    r_kinv   <= ~in_k;
                    r_sticky <= 1'b0;
                    r_zero_q <= in_zero;
                    r_stage  <= '0;
                    r_state  <= SHIFT;
                end
                SHIFT: begin
                    if (w_do) begin
                        r_acc    <= r_acc >> w_amt;
                        r_sticky <= r_sticky | (|(r_acc & w_mask));
                    end
                    r_stage <= (r_stage == NUM_STAGES - 3'd1) ? 3'd0 : r_stage + 3'd1;
                    if (r_stage == NUM_STAGES - 3'd1) r_state <= DONE;
                end
                DONE: if (out_ready) r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule
